mem_io_unit: RTL

Memory/IO access unit for the 16-bit core: takes one load or store request per instruction from execute, runs it on the data-memory bus or the IO bus with an acknowledge handshake, and stalls the pipeline until it completes. Sits directly upstream of the writeback mux. `rdata_mem` feeds the mux's memory input (`wb_sel` 3'b010) and `rdata_io` feeds its IO input (`wb_sel` 3'b011).

---
 rtl/mem_io_pkg.sv | 14 +
 rtl/mem_io_unit_if.sv | 48 ++++
 rtl/mem_io_timeout_ctr.sv | 24 ++
 rtl/mem_io_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/IO access unit.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IO_WAIT,
    DONE
  } mem_io_state_t;

  localparam int          MEM_IO_TIMEOUT_DEFAULT = 255;
  localparam logic [15:0] MEM_IO_FAULT_DATA      = 16'hFFFF;

endpackage

// File: rtl/mem_io_unit_if.sv
// Execute-side request/retire signals plus the memory and IO bus handshakes.
// master: the access unit; slave: execute stage and bus targets.
interface mem_io_unit_if;

  logic        req_valid;
  logic        req_we;
  logic        req_io;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [15:0] rdata_mem;
  logic [15:0] rdata_io;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  logic        io_req;
  logic        io_we;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        io_ack;

  modport master (
    input  req_valid, req_we, req_io, req_addr, req_wdata,
    output stall, done, fault, rdata_mem, rdata_io,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output io_req, io_we, io_addr, io_wdata,
    input  io_rdata, io_ack
  );

  modport slave (
    output req_valid, req_we, req_io, req_addr, req_wdata,
    input  stall, done, fault, rdata_mem, rdata_io,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  io_req, io_we, io_addr, io_wdata,
    output io_rdata, io_ack
  );

endinterface

// File: rtl/mem_io_timeout_ctr.sv
// Bus-wait counter: expired is high on the wait cycle whose edge would bring
// the count up to limit, so the abort lands exactly limit wait cycles in.
module mem_io_timeout_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == limit - 8'd1);

endmodule

// File: rtl/mem_io_unit.sv
// Load/store unit: runs one access per instruction on the memory or IO bus
// and stalls execute until the ack. Optional bus timeout: MEM_IO_TIMEOUT_EN.
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_IO_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mem_io_unit_if.master b
);

  mem_io_state_t state;
  logic          accept;
  logic          timeout_hit;

  assign accept  = (state == IDLE) && b.req_valid;
  assign b.stall = accept || (state == MEM_WAIT) || (state == IO_WAIT);

`ifdef MEM_IO_TIMEOUT_EN
  logic wait_enable;

  assign wait_enable = ((state == MEM_WAIT) && !b.mem_ack) ||
                       ((state == IO_WAIT)  && !b.io_ack);

  mem_io_timeout_ctr u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (wait_enable),
    .limit   (8'(TIMEOUT_CYCLES)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  assign b.fault     = 1'b0;
`endif

  // The bus output registers double as the captured request: they hold
  // we/addr/wdata steady for the whole wait and tell us load vs store at ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      b.done      <= 1'b0;
      b.rdata_mem <= '0;
      b.rdata_io  <= '0;
      b.mem_req   <= 1'b0;
      b.mem_we    <= 1'b0;
      b.mem_addr  <= '0;
      b.mem_wdata <= '0;
      b.io_req    <= 1'b0;
      b.io_we     <= 1'b0;
      b.io_addr   <= '0;
      b.io_wdata  <= '0;
`ifdef MEM_IO_TIMEOUT_EN
      b.fault     <= 1'b0;
`endif
    end else begin
      b.done <= 1'b0;
`ifdef MEM_IO_TIMEOUT_EN
      b.fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (b.req_valid) begin
            if (b.req_io) begin
              state      <= IO_WAIT;
              b.io_req   <= 1'b1;
              b.io_we    <= b.req_we;
              b.io_addr  <= b.req_addr;
              b.io_wdata <= b.req_wdata;
            end else begin
              state       <= MEM_WAIT;
              b.mem_req   <= 1'b1;
              b.mem_we    <= b.req_we;
              b.mem_addr  <= b.req_addr;
              b.mem_wdata <= b.req_wdata;
            end
          end
        end
        MEM_WAIT: begin
          if (b.mem_ack || timeout_hit) begin
            if (!b.mem_we) begin
              b.rdata_mem <= b.mem_ack ? b.mem_rdata : MEM_IO_FAULT_DATA;
            end
            b.mem_req   <= 1'b0;
            b.mem_we    <= 1'b0;
            b.mem_addr  <= '0;
            b.mem_wdata <= '0;
            b.done      <= 1'b1;
            state       <= DONE;
`ifdef MEM_IO_TIMEOUT_EN
            b.fault     <= !b.mem_ack;
`endif
          end
        end
        IO_WAIT: begin
          if (b.io_ack || timeout_hit) begin
            if (!b.io_we) begin
              b.rdata_io <= b.io_ack ? b.io_rdata : MEM_IO_FAULT_DATA;
            end
            b.io_req   <= 1'b0;
            b.io_we    <= 1'b0;
            b.io_addr  <= '0;
            b.io_wdata <= '0;
            b.done     <= 1'b1;
            state      <= DONE;
`ifdef MEM_IO_TIMEOUT_EN
            b.fault    <= !b.io_ack;
`endif
          end
        end
        // req_valid here still belongs to the retiring instruction.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
